// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: 32x32 register file, RV32-style field decode, load-use stall.
// Optional REGFILE_BYPASS_EN: same-cycle writeback data is forwarded to the operand reads.
module decode_stage #(
  parameter int unsigned NUM_REGS     = 32,
  parameter logic [31:0] RESET_PC_NOP = 32'h00000013
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [31:0]                 instr,
  input  logic                        flush,
  input  logic                        wb_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_addr,
  input  logic [31:0]                 wb_data,
  output logic [31:0]                 op1,
  output logic [31:0]                 op2,
  output logic [6:0]                  aluOp,
  output logic [$clog2(NUM_REGS)-1:0] ex_rd,
  output logic                        ex_reg_write,
  output logic                        ex_is_load,
  output logic                        ex_valid,
  output logic                        stall_out
);

  localparam int unsigned AW      = $clog2(NUM_REGS);
  localparam logic [6:0]  OPC_R   = 7'b0110011;
  localparam logic [6:0]  OPC_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LD  = 7'b0000011;
  localparam logic [6:0]  OPC_ST  = 7'b0100011;
  localparam logic [6:0]  OPC_NOP = RESET_PC_NOP[6:0];

  logic [31:0]   r_regs [NUM_REGS];
  logic [31:0]   r_op1;
  logic [31:0]   r_op2;
  logic [6:0]    r_alu_op;
  logic [AW-1:0] r_ex_rd;
  logic          r_ex_reg_write;
  logic          r_ex_is_load;
  logic          r_ex_valid;

  logic [6:0]    w_opcode;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] w_rs1;
  logic [AW-1:0] w_rs2;
  logic [31:0]   w_imm_i;
  logic [31:0]   w_imm_s;
  logic          w_is_r;
  logic          w_is_imm;
  logic          w_is_load;
  logic          w_is_store;
  logic          w_supported;
  logic [31:0]   w_rs1_val;
  logic [31:0]   w_rs2_val;
  logic [31:0]   w_op2;
  logic          w_hazard;
  logic          w_issue;
  logic          w_unused_funct3;

  assign w_opcode        = instr[6:0];
  assign w_rd            = instr[11:7];
  assign w_rs1           = instr[19:15];
  assign w_rs2           = instr[24:20];
  assign w_imm_i         = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_unused_funct3 = ^instr[14:12];

  assign w_is_r      = (w_opcode == OPC_R);
  assign w_is_imm    = (w_opcode == OPC_IMM);
  assign w_is_load   = (w_opcode == OPC_LD);
  assign w_is_store  = (w_opcode == OPC_ST);
  assign w_supported = w_is_r | w_is_imm | w_is_load | w_is_store;

  always_comb begin
    w_rs1_val = (w_rs1 == '0) ? 32'h0 : r_regs[w_rs1];
    w_rs2_val = (w_rs2 == '0) ? 32'h0 : r_regs[w_rs2];
`ifdef REGFILE_BYPASS_EN
    // Write-first: a nonzero wb_addr match implies the read index is nonzero too.
    if (wb_en && (wb_addr != '0) && (wb_addr == w_rs1)) w_rs1_val = wb_data;
    if (wb_en && (wb_addr != '0) && (wb_addr == w_rs2)) w_rs2_val = wb_data;
`endif
  end

  assign w_op2 = w_is_r     ? w_rs2_val :
                 w_is_store ? w_imm_s   : w_imm_i;

  // rs2 only counts as a source for formats that actually read it.
  assign w_hazard = in_valid && r_ex_valid && r_ex_is_load && (r_ex_rd != '0) &&
                    ((r_ex_rd == w_rs1) || ((w_is_r || w_is_store) && (r_ex_rd == w_rs2)));

  assign stall_out = w_hazard && !flush && !reset;
  assign w_issue   = in_valid && !flush && !w_hazard && w_supported;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'h0;
      r_op1          <= 32'h0;
      r_op2          <= 32'h0;
      r_alu_op       <= OPC_NOP;
      r_ex_rd        <= '0;
      r_ex_reg_write <= 1'b0;
      r_ex_is_load   <= 1'b0;
      r_ex_valid     <= 1'b0;
    end else begin
      if (wb_en && (wb_addr != '0)) r_regs[wb_addr] <= wb_data;
      if (w_issue) begin
        r_op1          <= w_rs1_val;
        r_op2          <= w_op2;
        r_alu_op       <= w_opcode;
        r_ex_rd        <= w_is_store ? '0 : w_rd;
        r_ex_reg_write <= !w_is_store;
        r_ex_is_load   <= w_is_load;
        r_ex_valid     <= 1'b1;
      end else begin
        r_op1          <= 32'h0;
        r_op2          <= 32'h0;
        r_alu_op       <= OPC_NOP;
        r_ex_rd        <= '0;
        r_ex_reg_write <= 1'b0;
        r_ex_is_load   <= 1'b0;
        r_ex_valid     <= 1'b0;
      end
    end
  end

  assign op1          = r_op1;
  assign op2          = r_op2;
  assign aluOp        = r_alu_op;
  assign ex_rd        = r_ex_rd;
  assign ex_reg_write = r_ex_reg_write;
  assign ex_is_load   = r_ex_is_load;
  assign ex_valid     = r_ex_valid;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected EX-slot contents are queued per driven cycle.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [6:0]  aop;
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
    logic        vld;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [6:0]  aluOp;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_is_load;
  logic        ex_valid;
  logic        stall_out;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_OP1 = 32'h0000_1234;
`else
  localparam logic [31:0] BYP_OP1 = 32'h0000_0007;
`endif

  decode_stage u_dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .instr       (instr),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .op1         (op1),
    .op2         (op2),
    .aluOp       (aluOp),
    .ex_rd       (ex_rd),
    .ex_reg_write(ex_reg_write),
    .ex_is_load  (ex_is_load),
    .ex_valid    (ex_valid),
    .stall_out   (stall_out)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t bub();
    exp_t e;
    e = '{op1: 32'h0, op2: 32'h0, aop: 7'h13, rd: 5'd0, rw: 1'b0, ld: 1'b0, vld: 1'b0};
    return e;
  endfunction

  function automatic exp_t iss(input logic [31:0] a, input logic [31:0] b, input logic [6:0] aop,
                               input logic [4:0] rd, input logic rw, input logic ld);
    exp_t e;
    e = '{op1: a, op2: b, aop: aop, rd: rd, rw: rw, ld: ld, vld: 1'b1};
    return e;
  endfunction

  // Drive one cycle of inputs, check stall_out before the edge, then compare the EX slot after it.
  task automatic step(input string tag, input logic rst, input logic v, input logic [31:0] ins,
                      input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic stall_exp, input exp_t e);
    exp_t x;
    reset    = rst;
    in_valid = v;
    instr    = ins;
    flush    = fl;
    wb_en    = we;
    wb_addr  = wa;
    wb_data  = wd;
    #1;
    check_eq({tag, ".stall"}, {31'h0, stall_out}, {31'h0, stall_exp});
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s.sb: got empty queue expected entry", tag);
    end else begin
      x = sb.pop_front();
      check_eq({tag, ".op1"}, op1, x.op1);
      check_eq({tag, ".op2"}, op2, x.op2);
      check_eq({tag, ".aluOp"}, {25'h0, aluOp}, {25'h0, x.aop});
      check_eq({tag, ".ex_rd"}, {27'h0, ex_rd}, {27'h0, x.rd});
      check_eq({tag, ".reg_write"}, {31'h0, ex_reg_write}, {31'h0, x.rw});
      check_eq({tag, ".is_load"}, {31'h0, ex_is_load}, {31'h0, x.ld});
      check_eq({tag, ".valid"}, {31'h0, ex_valid}, {31'h0, x.vld});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, including a writeback that must lose to reset.
    step("rst0", 1, 0, 32'h0000_0013, 0, 0, 5'd0, 32'h0, 0, bub());
    step("rst1", 1, 1, 32'h0062_83B3, 0, 1, 5'd5, 32'd99, 0, bub());
    step("add_zero", 0, 1, 32'h0062_83B3, 0, 0, 5'd0, 32'h0, 0, iss(0, 0, 7'h33, 5'd7, 1, 0));
    step("wb_x5", 0, 0, 32'h0, 0, 1, 5'd5, 32'd7, 0, bub());
    step("wb_x6", 0, 0, 32'h0, 0, 1, 5'd6, 32'd3, 0, bub());
    step("add", 0, 1, 32'h0062_83B3, 0, 0, 5'd0, 32'h0, 0, iss(7, 3, 7'h33, 5'd7, 1, 0));
    step("addi", 0, 1, 32'hFFF0_0413, 0, 0, 5'd0, 32'h0, 0,
         iss(0, 32'hFFFF_FFFF, 7'h13, 5'd8, 1, 0));
    // Load-use: one stall cycle, then the dependent add issues.
    step("lw", 0, 1, 32'h0002_A483, 0, 0, 5'd0, 32'h0, 0, iss(7, 0, 7'h03, 5'd9, 1, 1));
    step("lu_stall", 0, 1, 32'h0064_8533, 0, 1, 5'd9, 32'h55, 1, bub());
    step("lu_issue", 0, 1, 32'h0064_8533, 0, 0, 5'd0, 32'h0, 0,
         iss(32'h55, 3, 7'h33, 5'd10, 1, 0));
    // Same-cycle writeback vs read.
    step("byp", 0, 1, 32'h0062_83B3, 0, 1, 5'd5, 32'h1234, 0,
         iss(BYP_OP1, 3, 7'h33, 5'd7, 1, 0));
    step("byp_after", 0, 1, 32'h0062_83B3, 0, 0, 5'd0, 32'h0, 0,
         iss(32'h1234, 3, 7'h33, 5'd7, 1, 0));
    // x0 stays zero.
    step("wb_x0", 0, 0, 32'h0, 0, 1, 5'd0, 32'hDEAD, 0, bub());
    step("rd_x0", 0, 1, 32'h0060_05B3, 0, 1, 5'd0, 32'hDEAD, 0, iss(0, 3, 7'h33, 5'd11, 1, 0));
    // Flush during a would-be stall.
    step("lw2", 0, 1, 32'h0002_A483, 0, 0, 5'd0, 32'h0, 0, iss(32'h1234, 0, 7'h03, 5'd9, 1, 1));
    step("flush", 0, 1, 32'h0064_8533, 1, 0, 5'd0, 32'h0, 0, bub());
    step("post_flush", 0, 1, 32'h0064_8533, 0, 0, 5'd0, 32'h0, 0,
         iss(32'h55, 3, 7'h33, 5'd10, 1, 0));
    // Stores: positive and negative split immediates.
    step("sw_pos", 0, 1, 32'h0062_A223, 0, 0, 5'd0, 32'h0, 0, iss(32'h1234, 4, 7'h23, 5'd0, 0, 0));
    step("sw_neg", 0, 1, 32'hFE62_AC23, 0, 0, 5'd0, 32'h0, 0,
         iss(32'h1234, 32'hFFFF_FFF8, 7'h23, 5'd0, 0, 0));
    // Unsupported opcode and in_valid=0 both yield bubbles.
    step("bad_opc", 0, 1, 32'h0000_007F, 0, 0, 5'd0, 32'h0, 0, bub());
    step("no_valid", 0, 0, 32'h0062_83B3, 0, 0, 5'd0, 32'h0, 0, bub());
    // I-type whose imm bits alias ex_rd in the rs2 position must not stall.
    step("lw_x0b", 0, 1, 32'h0000_2483, 0, 0, 5'd0, 32'h0, 0, iss(0, 0, 7'h03, 5'd9, 1, 1));
    step("addi_nost", 0, 1, 32'h0090_8613, 0, 0, 5'd0, 32'h0, 0, iss(0, 9, 7'h13, 5'd12, 1, 0));
    // Load to x0 never causes a stall.
    step("lw_rd0", 0, 1, 32'h0000_2003, 0, 0, 5'd0, 32'h0, 0, iss(0, 0, 7'h03, 5'd0, 1, 1));
    step("add_x0x0", 0, 1, 32'h0000_06B3, 0, 0, 5'd0, 32'h0, 0, iss(0, 0, 7'h33, 5'd13, 1, 0));
    // Store rs2 hazard, then reset asserted during the stall.
    step("lw3", 0, 1, 32'h0002_A483, 0, 0, 5'd0, 32'h0, 0, iss(32'h1234, 0, 7'h03, 5'd9, 1, 1));
    step("sw_stall", 0, 1, 32'h0092_A023, 0, 0, 5'd0, 32'h0, 1, bub());
    step("rst_stall", 1, 1, 32'h0092_A023, 0, 0, 5'd0, 32'h0, 0, bub());
    step("post_rst", 0, 1, 32'h0092_A023, 0, 0, 5'd0, 32'h0, 0, iss(0, 0, 7'h23, 5'd0, 0, 0));
    step("post_rst_x6", 0, 1, 32'h0062_83B3, 0, 0, 5'd0, 32'h0, 0, iss(0, 0, 7'h33, 5'd7, 1, 0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
